// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared state encodings and width helper for the frame synchroniser
// Contents:
//   STATE_W  width of the FSM state / state_o
//   state_t  ST_HUNT=00, ST_VERIFY=01, ST_LOCKED=10
//   clog2    ceil(log2(v)) for sizing counters
package frame_sync_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_sync_ctrl_if.sv
// rtl/frame_sync_ctrl_if.sv - serial input / parallel payload bundle of the frame synchroniser
// Signals:
//   din_valid, din               serial bit in, sampled only when din_valid=1
//   payload_valid, payload_data  1-cycle pulse with a complete payload, first bit in MSB
// Modports: master = line side / consumer, slave = frame_sync_ctrl
interface frame_sync_ctrl_if #(
    parameter int PAYLOAD_LEN = 8
);
    logic                   din_valid;
    logic                   din;
    logic                   payload_valid;
    logic [PAYLOAD_LEN-1:0] payload_data;

    modport master (
        output din_valid,
        output din,
        input  payload_valid,
        input  payload_data
    );

    modport slave (
        input  din_valid,
        input  din,
        output payload_valid,
        output payload_data
    );
endinterface

// File: rtl/sync_pattern_matcher.sv
// rtl/sync_pattern_matcher.sv - sync-word shift register and compare
// Ports:
//   clk, rst_n        clock, async active-low reset
//   enable, din_valid shift only when both are 1
//   din               serial bit
//   match             1 when the window including this bit equals SYNC_PATTERN (valid bits only)
//   window            shift-register contents including the current bit
module sync_pattern_matcher #(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              din_valid,
    input  logic              din,
    output logic              match,
    output logic [SYNC_W-1:0] window
);

    logic [SYNC_W-1:0] sr_q;

    // The compare looks at the window as it will be after this bit, so the
    // controller can react on the same edge that samples the last sync bit.
    assign window = {sr_q[SYNC_W-2:0], din};
    assign match  = enable && din_valid && (window == SYNC_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (enable && din_valid) begin
            sr_q <= window;
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// rtl/frame_sync_ctrl.sv - serial frame synchroniser: hunt, verify, lock, payload delivery
// Ports:
//   clk, rst_n   clock, async active-low reset
//   enable       0 forces HUNT and clears counters and pulses
//   bus          slave side of frame_sync_ctrl_if (din/din_valid in, payload out)
//   frame_start  pulse: sync word accepted
//   locked       1 while in LOCKED
//   sync_err     pulse: bad sync slot in VERIFY or LOCKED
//   state_o      00 HUNT, 01 VERIFY, 10 LOCKED
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1101,
    parameter int                PAYLOAD_LEN  = 8,
    parameter int                LOCK_CNT     = 2,
    parameter int                MISS_MAX     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    frame_sync_ctrl_if.slave   bus,
    output logic               frame_start,
    output logic               locked,
    output logic               sync_err,
    output logic [STATE_W-1:0] state_o
);

    localparam int FRAME_LEN = SYNC_W + PAYLOAD_LEN;
    localparam int CNT_W     = clog2(FRAME_LEN);
    localparam int GOOD_W    = clog2(LOCK_CNT + 1);
    localparam int MISS_W    = clog2(MISS_MAX + 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic [PAYLOAD_LEN-1:0] psr_q, psr_d;
    logic [PAYLOAD_LEN-1:0] pdata_q, pdata_d;
    logic                   fs_q, fs_d;
    logic                   pv_q, pv_d;
    logic                   se_q, se_d;

    logic                   match;
    logic [SYNC_W-1:0]      window;
    logic                   slot_ok;
    logic                   slot_end;
    logic                   in_payload;
    logic                   last_pay;
    logic [PAYLOAD_LEN-1:0] pay_next;
    logic [GOOD_W-1:0]      good_inc;
    logic [MISS_W-1:0]      miss_inc;

    sync_pattern_matcher #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_matcher (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .din_valid (bus.din_valid),
        .din       (bus.din),
        .match     (match),
        .window    (window)
    );

    // Slot checks are only evaluated inside the valid-bit branch below, so
    // the raw window compare is sufficient there.
    assign slot_ok    = (window == SYNC_PATTERN);
    assign slot_end   = (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign in_payload = (cnt_q < CNT_W'(PAYLOAD_LEN));
    assign last_pay   = (cnt_q == CNT_W'(PAYLOAD_LEN - 1));
    // Shift form works for PAYLOAD_LEN=1 as well as wider payloads.
    assign pay_next   = (psr_q << 1) | PAYLOAD_LEN'(bus.din);
    assign good_inc   = good_q + GOOD_W'(1);
    assign miss_inc   = miss_q + MISS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            cnt_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            psr_q   <= '0;
            pdata_q <= '0;
            fs_q    <= 1'b0;
            pv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            psr_q   <= psr_d;
            pdata_q <= pdata_d;
            fs_q    <= fs_d;
            pv_q    <= pv_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        miss_d  = miss_q;
        psr_d   = psr_q;
        pdata_d = pdata_q;
        fs_d    = 1'b0;
        pv_d    = 1'b0;
        se_d    = 1'b0;

        if (!enable) begin
            state_d = ST_HUNT;
            cnt_d   = '0;
            good_d  = '0;
            miss_d  = '0;
        end else if (bus.din_valid) begin
            cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);

            // Payload bits are collected on the current frame grid in every
            // state, but only published once the frame is locked.
            if (in_payload) begin
                psr_d = pay_next;
                if (last_pay && state_q == ST_LOCKED) begin
                    pdata_d = pay_next;
                    pv_d    = 1'b1;
                end
            end

            case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        fs_d   = 1'b1;
                        cnt_d  = '0;
                        good_d = GOOD_W'(1);
                        miss_d = '0;
                        state_d = (LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (slot_end) begin
                        if (slot_ok) begin
                            fs_d   = 1'b1;
                            good_d = good_inc;
                            if (good_inc == GOOD_W'(LOCK_CNT)) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            se_d    = 1'b1;
                            good_d  = '0;
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (slot_end) begin
                        if (slot_ok) begin
                            fs_d   = 1'b1;
                            miss_d = '0;
                        end else begin
                            se_d   = 1'b1;
                            miss_d = miss_inc;
                            if (miss_inc == MISS_W'(MISS_MAX)) begin
                                state_d = ST_HUNT;
                                miss_d  = '0;
                                good_d  = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    assign frame_start       = fs_q;
    assign sync_err          = se_q;
    assign locked            = (state_q == ST_LOCKED);
    assign state_o           = state_q;
    assign bus.payload_valid = pv_q;
    assign bus.payload_data  = pdata_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb/tb_frame_sync_ctrl.sv - directed self-checking bench for frame_sync_ctrl
module tb_frame_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic [1:0] state_o;

    frame_sync_ctrl_if #(.PAYLOAD_LEN(8)) bus ();

    frame_sync_ctrl #(
        .SYNC_W       (4),
        .SYNC_PATTERN (4'b1101),
        .PAYLOAD_LEN  (8),
        .LOCK_CNT     (2),
        .MISS_MAX     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus.slave),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         bitn;
    int         idle_bad;
    logic       fs_log [0:127];
    logic       pv_log [0:127];
    logic       se_log [0:127];
    logic [1:0] st_log [0:127];
    logic [7:0] pd_log [0:127];

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        bus.din       = b;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        if (bitn < 127) bitn++;
        fs_log[bitn] = frame_start;
        pv_log[bitn] = bus.payload_valid;
        se_log[bitn] = sync_err;
        st_log[bitn] = state_o;
        pd_log[bitn] = bus.payload_data;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (frame_start !== 1'b0 || bus.payload_valid !== 1'b0 ||
                sync_err !== 1'b0 || state_o !== st_log[bitn])
                idle_bad++;
        end
    endtask

    task automatic send_word(input logic [15:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i], (gap != 0) ? int'($urandom_range(1, 3)) : 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        enable        = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        bitn     = 0;
        idle_bad = 0;
    endtask

    task automatic test_reset();
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        rst_n         = 1'b0;
        #1;
        tests++;
        if (state_o !== 2'b00 || locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: state=%b locked=%b, want 00/0", state_o, locked);
        end
        tests++;
        if (frame_start !== 1'b0 || sync_err !== 1'b0 || bus.payload_valid !== 1'b0 ||
            bus.payload_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: fs=%b se=%b pv=%b pd=%h, want 0/0/0/00",
                     frame_start, sync_err, bus.payload_valid, bus.payload_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bitn  = 0;
        send_word(16'hD, 4, 0);
        tests++;
        if (frame_start !== 1'b1 || state_o !== 2'b01) begin
            fails++;
            $display("FAIL pre_reset_hit: fs=%b state=%b, want 1/01", frame_start, state_o);
        end
        // asynchronous reset while the pulse is showing
        rst_n = 1'b0;
        #1;
        tests++;
        if (frame_start !== 1'b0 || state_o !== 2'b00 || locked !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: fs=%b state=%b locked=%b, want 0/00/0",
                     frame_start, state_o, locked);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bitn  = 0;
        send_word(16'h000, 12, 0);
        send_word(16'hD, 4, 0);
        begin
            int bad = 0;
            for (int i = 1; i <= 16; i++) begin
                if (fs_log[i] !== (i == 16)) bad++;
                if (pv_log[i] !== 1'b0 || se_log[i] !== 1'b0) bad++;
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL post_reset_quiet: %0d wrong pulse bits, want 0 (fs only at bit 16)", bad);
            end
        end
    endtask

    task automatic run_lock_seq(input int gap, input string tag);
        int fs_bad = 0;
        int pv_bad = 0;
        bitn     = 0;
        idle_bad = 0;
        send_word(16'hD, 4, gap);
        send_word(16'hA5, 8, gap);
        send_word(16'hD, 4, gap);
        send_word(16'h3C, 8, gap);
        send_word(16'hD, 4, gap);
        for (int i = 1; i <= 28; i++) begin
            if (fs_log[i] !== (i == 4 || i == 16 || i == 28)) fs_bad++;
            if (pv_log[i] !== (i == 24) || se_log[i] !== 1'b0) pv_bad++;
        end
        tests++;
        if (fs_bad != 0) begin
            fails++;
            $display("FAIL %s frame_start: %0d wrong bits, want 0 (pulses at 4/16/28)", tag, fs_bad);
        end
        tests++;
        if (pv_bad != 0) begin
            fails++;
            $display("FAIL %s payload/sync_err: %0d wrong bits, want 0 (valid only at 24)", tag, pv_bad);
        end
        tests++;
        if (pd_log[24] !== 8'h3C) begin
            fails++;
            $display("FAIL %s payload_data: got %h, want 3c", tag, pd_log[24]);
        end
        tests++;
        if (st_log[3] !== 2'b00 || st_log[4] !== 2'b01 || st_log[15] !== 2'b01 ||
            st_log[16] !== 2'b10 || st_log[28] !== 2'b10) begin
            fails++;
            $display("FAIL %s states: b3=%b b4=%b b15=%b b16=%b b28=%b, want 00 01 01 10 10",
                     tag, st_log[3], st_log[4], st_log[15], st_log[16], st_log[28]);
        end
        if (gap != 0) begin
            tests++;
            if (idle_bad != 0) begin
                fails++;
                $display("FAIL %s idle_cycles: %0d disturbed idle cycles, want 0", tag, idle_bad);
            end
        end
    endtask

    task automatic test_lock();
        run_lock_seq(0, "lock");
    endtask

    task automatic test_payload_sync();
        int bad = 0;
        send_word(16'hDD, 8, 0);
        send_word(16'hD, 4, 0);
        for (int i = 29; i <= 40; i++) begin
            if (fs_log[i] !== (i == 40)) bad++;
            if (pv_log[i] !== (i == 36)) bad++;
            if (st_log[i] !== 2'b10) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL payload_sync events: %0d wrong bits, want 0", bad);
        end
        tests++;
        if (pd_log[36] !== 8'hDD) begin
            fails++;
            $display("FAIL payload_sync data: got %h, want dd", pd_log[36]);
        end
    endtask

    task automatic test_miss();
        int bad = 0;
        send_word(16'h00F, 12, 0);
        send_word(16'h00D, 12, 0);
        send_word(16'h00F, 12, 0);
        send_word(16'h00F, 12, 0);
        for (int i = 41; i <= 88; i++) begin
            if (se_log[i] !== (i == 52 || i == 76 || i == 88)) bad++;
            if (fs_log[i] !== (i == 64)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL miss events: %0d wrong bits, want 0 (err 52/76/88, start 64)", bad);
        end
        tests++;
        if (st_log[52] !== 2'b10 || st_log[76] !== 2'b10 || st_log[87] !== 2'b10) begin
            fails++;
            $display("FAIL miss single_bad_keeps_lock: b52=%b b76=%b b87=%b, want 10",
                     st_log[52], st_log[76], st_log[87]);
        end
        tests++;
        if (st_log[88] !== 2'b00 || locked !== 1'b0) begin
            fails++;
            $display("FAIL miss drop_lock: state=%b locked=%b, want 00/0", st_log[88], locked);
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        run_lock_seq(1, "gaps");
    endtask

    task automatic test_enable();
        int bad = 0;
        apply_reset();
        run_lock_seq(0, "pre_enable");
        send_word(16'hA, 4, 0);
        for (int i = 29; i <= 32; i++)
            if (pv_log[i] !== 1'b0 || st_log[i] !== 2'b10) bad++;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        if (bus.payload_valid !== 1'b0 || frame_start !== 1'b0) bad++;
        tests++;
        if (state_o !== 2'b00 || locked !== 1'b0 || bad != 0) begin
            fails++;
            $display("FAIL enable_drop: state=%b locked=%b bad=%0d, want 00/0/0", state_o, locked, bad);
        end
        @(negedge clk);
        enable = 1'b1;
        run_lock_seq(0, "relock");
    endtask

    initial begin
        bitn     = 0;
        idle_bad = 0;
        test_reset();
        apply_reset();
        test_lock();
        test_payload_sync();
        test_miss();
        test_gaps();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
